// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode values and FSM state encoding.
package alu_arbiter_pkg;

    localparam int unsigned ALU_OP_ADD  = 0;
    localparam int unsigned ALU_OP_SUB  = 1;
    localparam int unsigned ALU_OP_AND  = 2;
    localparam int unsigned ALU_OP_OR   = 3;
    localparam int unsigned ALU_OP_XOR  = 4;
    localparam int unsigned ALU_OP_PASS = 5;
    localparam int unsigned ALU_OP_SHL  = 6;
    localparam int unsigned ALU_OP_SHR  = 7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: result plus zero/carry/negative flags.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned OP_W   = 3
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   ALU_OP,
    output logic [DATA_W-1:0] result,
    output logic              Z,
    output logic              C,
    output logic              N
);

    // Top bit is the carry: carry-out for ADD, borrow for SUB, shifted-out bit for shifts.
    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (ALU_OP)
            OP_W'(ALU_OP_ADD):  wide = {1'b0, a} + {1'b0, b};
            OP_W'(ALU_OP_SUB):  wide = {1'b0, a} - {1'b0, b};
            OP_W'(ALU_OP_AND):  wide = {1'b0, a & b};
            OP_W'(ALU_OP_OR):   wide = {1'b0, a | b};
            OP_W'(ALU_OP_XOR):  wide = {1'b0, a ^ b};
            OP_W'(ALU_OP_PASS): wide = {1'b0, a};
            OP_W'(ALU_OP_SHL):  wide = {a, 1'b0};
            OP_W'(ALU_OP_SHR):  wide = {a[0], 1'b0, a[DATA_W-1:1]};
            default:            wide = '0;
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign C      = wide[DATA_W];
    assign Z      = (result == '0);
    assign N      = result[DATA_W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared ALU, one op per 3 cycles.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              valid0,
    output logic              valid1,
    output logic [DATA_W-1:0] result_q,
    output logic              z_q,
    output logic              c_q,
    output logic              n_q,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              win_sel;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] result_d;
    logic              z_d, c_d, n_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_z, alu_c, alu_n;

    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .ALU_OP (op_q),
        .result (alu_result),
        .Z      (alu_z),
        .C      (alu_c),
        .N      (alu_n)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        n_d      = n_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        // On a tie the requester not served last wins; otherwise the lone requester.
        win_sel  = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    win_d   = win_sel;
                    last_d  = win_sel;
                    a_d     = win_sel ? a1 : a0;
                    b_d     = win_sel ? b1 : b0;
                    op_d    = win_sel ? op1 : op0;
                    gnt0_d  = ~win_sel;
                    gnt1_d  = win_sel;
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d = alu_result;
                z_d      = alu_z;
                c_d      = alu_c;
                n_d      = alu_n;
                valid0_d = ~win_q;
                valid1_d = win_q;
                state_d  = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            n_q      <= n_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign valid0 = valid0_q;
    assign valid1 = valid1_q;
    assign busy   = busy_q;

endmodule
